l2_bus_adapter: RTL

L2_BUS_ADAPTER -- requirements
Module: l2_bus_adapter

---
 rtl/l2_bus_adapter_if.sv | 33 +++
 rtl/l2_bus_adapter.sv | 121 ++++++++++++
 2 files changed

// File: rtl/l2_bus_adapter_if.sv
// Bus bundle for the L2 bus adapter: bus-controller request/response
// signals on one side and the single-word memory port on the other.
interface l2_bus_adapter_if #(
  parameter int BLOCK_SIZE = 2,
  parameter int WORD_W     = 32
);
  logic                         l2REN;
  logic                         l2WEN;
  logic [WORD_W-1:0]            l2addr;
  logic [BLOCK_SIZE*WORD_W-1:0] l2store;
  logic [BLOCK_SIZE*WORD_W-1:0] l2load;
  logic [1:0]                   l2state;
  logic                         mem_ren;
  logic                         mem_wen;
  logic [WORD_W-1:0]            mem_addr;
  logic [WORD_W-1:0]            mem_wdata;
  logic [WORD_W-1:0]            mem_rdata;
  logic                         mem_busy;
  logic                         mem_error;

  // Adapter view: requests and memory responses come in, block data,
  // status and memory strobes go out.
  modport slave (
    input  l2REN, l2WEN, l2addr, l2store, mem_rdata, mem_busy, mem_error,
    output l2load, l2state, mem_ren, mem_wen, mem_addr, mem_wdata
  );

  // Environment view: bus controller plus memory model.
  modport master (
    output l2REN, l2WEN, l2addr, l2store, mem_rdata, mem_busy, mem_error,
    input  l2load, l2state, mem_ren, mem_wen, mem_addr, mem_wdata
  );
endinterface

// File: rtl/l2_bus_adapter.sv
// L2 bus adapter: turns a block read / write-back request from the bus
// controller into BLOCK_SIZE sequential single-word memory accesses.
// The request is latched on acceptance, so the controller may change or
// drop its inputs while the block is in flight.
module l2_bus_adapter #(
  parameter int BLOCK_SIZE = 2,
  parameter int WORD_W     = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  l2_bus_adapter_if.slave   bus
);

  localparam int BLOCK_BYTES = BLOCK_SIZE * WORD_W / 8;
  localparam int OFFSET_BITS = $clog2(BLOCK_BYTES);
  localparam int WORD_SHIFT  = $clog2(WORD_W / 8);
  localparam int IDX_W       = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(BLOCK_SIZE - 1);
  localparam logic [WORD_W-1:0] BASE_MASK = {WORD_W{1'b1}} << OFFSET_BITS;

  localparam logic [1:0] L2_FREE   = 2'd0;
  localparam logic [1:0] L2_BUSY   = 2'd1;
  localparam logic [1:0] L2_ACCESS = 2'd2;
  localparam logic [1:0] L2_ERROR  = 2'd3;

  typedef enum logic [1:0] {IDLE, XFER, DONE, FAIL} state_t;

  state_t                       state;
  state_t                       next_state;
  logic                         op_write;
  logic [WORD_W-1:0]            base;
  logic [BLOCK_SIZE*WORD_W-1:0] store_lat;
  logic [BLOCK_SIZE*WORD_W-1:0] load_reg;
  logic [IDX_W-1:0]             index;
  logic [31:0]                  word_lsb;
  logic                         req;
  logic                         word_ok;
  logic                         word_bad;
  logic                         last_word;

  assign req       = bus.l2REN | bus.l2WEN;
  assign word_ok   = !bus.mem_busy && !bus.mem_error;
  assign word_bad  = !bus.mem_busy && bus.mem_error;
  assign last_word = (index == LAST_IDX);
  assign word_lsb  = 32'(index) * 32'(WORD_W);
  assign bus.l2load = load_reg;

  // State register; reset aborts any transfer immediately.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic: one word per non-busy cycle, error ends the block early.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (req) next_state = XFER;
      XFER: begin
        if (word_bad)                    next_state = FAIL;
        else if (word_ok && last_word)   next_state = DONE;
      end
      DONE:    next_state = IDLE;
      FAIL:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Request latch, word index and read-data capture.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      op_write  <= 1'b0;
      base      <= '0;
      store_lat <= '0;
      load_reg  <= '0;
      index     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            op_write  <= bus.l2WEN;
            base      <= bus.l2addr & BASE_MASK;
            store_lat <= bus.l2store;
            index     <= '0;
          end
        end
        XFER: begin
          if (word_ok) begin
            if (!op_write) load_reg[word_lsb +: WORD_W] <= bus.mem_rdata;
            if (!last_word) index <= index + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Status and memory port outputs; strobes only ever active in XFER.
  always_comb begin
    bus.l2state   = L2_FREE;
    bus.mem_ren   = 1'b0;
    bus.mem_wen   = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    case (state)
      IDLE: bus.l2state = L2_FREE;
      XFER: begin
        bus.l2state   = L2_BUSY;
        bus.mem_ren   = !op_write;
        bus.mem_wen   = op_write;
        bus.mem_addr  = base + (WORD_W'(index) << WORD_SHIFT);
        bus.mem_wdata = store_lat[word_lsb +: WORD_W];
      end
      DONE:    bus.l2state = L2_ACCESS;
      FAIL:    bus.l2state = L2_ERROR;
      default: bus.l2state = L2_FREE;
    endcase
  end

endmodule
